// File: rtl/pending_encoder_8to3_pkg.sv
// Shared definitions for the pending request encoder.
// State encodings and default sizes.
package enc_defs;
    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;
endpackage

// File: rtl/pending_encoder_8to3_if.sv
// Request/offer bundle between event sources, encoder and consumer.
// The encoder is the slave; the driver/consumer side is the master.
interface pending_encoder_8to3_if
    import enc_defs::*;
#(
    parameter int N = N_REQ,
    parameter int W = CODE_W
);
    logic         En;
    logic [N-1:0] Req;
    logic         Ack;
    logic [W-1:0] Code;
    logic         Valid;
    logic [N-1:0] Pending;
    logic         Overrun;

    modport master (
        output En, Req, Ack,
        input  Code, Valid, Pending, Overrun
    );

    modport slave (
        input  En, Req, Ack,
        output Code, Valid, Pending, Overrun
    );
endinterface

// File: rtl/pending_encoder_8to3_rr_priority_select.sv
// Combinational selector: highest set index, or round-robin
// scan starting just after Start (rotate, scan, un-rotate).
module rr_priority_select #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] Pending,
    input  logic [W-1:0] Start,
    input  logic         Mode,
    output logic [W-1:0] Sel,
    output logic         Any
);
    logic [W-1:0] base;
    logic [W-1:0] idx;
    logic [N-1:0] rot;
    logic [W-1:0] lo;
    logic [W-1:0] hi;

    always_comb begin
        base = Mode ? W'(Start + 1'b1) : '0;
        rot  = '0;
        idx  = '0;
        for (int j = 0; j < N; j++) begin
            idx    = W'(base + W'(j));
            rot[j] = Pending[idx];
        end
    end

    // lo ends on the lowest set bit, hi on the highest
    always_comb begin
        lo = '0;
        hi = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) lo = W'(j);
        end
        for (int j = 0; j < N; j++) begin
            if (rot[j]) hi = W'(j);
        end
    end

    assign Sel = Mode ? W'(base + lo) : hi;
    assign Any = |Pending;
endmodule

// File: rtl/pending_encoder_8to3.sv
// Registered 8-to-3 request encoder with valid/ack handshake.
// Pending bits are captured, one is offered and held until acked.
module pending_encoder_8to3
    import enc_defs::*;
#(
    parameter int N       = N_REQ,
    parameter int W       = CODE_W,
    parameter int RR_MODE = 0
) (
    input  logic                     Clk,
    input  logic                     Resetn,
    pending_encoder_8to3_if.slave    bus
);
    localparam logic MODE = (RR_MODE != 0);

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] code_q, code_d;
    logic         valid_q, valid_d;
    logic [W-1:0] last_q, last_d;
    logic         ovr_q, ovr_d;

    logic [N-1:0] set_vec;
    logic [N-1:0] clr_vec;
    logic         clr;
    logic [W-1:0] sel;
    logic         any;

    rr_priority_select #(
        .N (N),
        .W (W)
    ) u_sel (
        .Pending (pend_q),
        .Start   (last_q),
        .Mode    (MODE),
        .Sel     (sel),
        .Any     (any)
    );

    assign clr = bus.En & valid_q & bus.Ack;

    always_comb begin
        set_vec = bus.En ? bus.Req : '0;
        clr_vec = '0;
        if (clr) clr_vec[code_q] = 1'b1;
        // a same-cycle request re-arms the bit being cleared
        pend_d = (pend_q & ~clr_vec) | set_vec;
        ovr_d  = ovr_q | (|(set_vec & pend_q & ~clr_vec));
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (!bus.En) begin
            state_d = ST_IDLE;
            code_d  = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        state_d = ST_OFFER;
                        code_d  = sel;
                        valid_d = 1'b1;
                    end
                end
                ST_OFFER: begin
                    if (bus.Ack) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = code_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= W'(N - 1);
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.Code    = code_q;
    assign bus.Valid   = valid_q;
    assign bus.Pending = pend_q;
    assign bus.Overrun = ovr_q;
endmodule

// File: tb/tb_pending_encoder_8to3.sv
// Directed bench: fixed-priority instance and round-robin instance
// share clock and reset; each step checked by immediate assertion.
module tb_pending_encoder_8to3;
    logic Clk = 1'b0;
    logic Resetn;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 Clk = ~Clk;

    pending_encoder_8to3_if #(.N(8), .W(3)) b0 ();
    pending_encoder_8to3_if #(.N(8), .W(3)) b1 ();

    pending_encoder_8to3 #(.N(8), .W(3), .RR_MODE(0)) dut0 (
        .Clk    (Clk),
        .Resetn (Resetn),
        .bus    (b0)
    );

    pending_encoder_8to3 #(.N(8), .W(3), .RR_MODE(1)) dut1 (
        .Clk    (Clk),
        .Resetn (Resetn),
        .bus    (b1)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Resetn = 1'b0;
        b0.En = 1'b1; b0.Req = 8'hFF; b0.Ack = 1'b0;
        b1.En = 1'b0; b1.Req = 8'h00; b1.Ack = 1'b0;
        tick(); tick();
        // 1: reset
        chk("rst_code",    32'(b0.Code),    0);
        chk("rst_valid",   32'(b0.Valid),   0);
        chk("rst_pending", 32'(b0.Pending), 0);
        chk("rst_overrun", 32'(b0.Overrun), 0);
        Resetn = 1'b1;
        tick();
        chk("rst_release_pending", 32'(b0.Pending), 32'hFF);
        b0.Req = 8'h00;
        Resetn = 1'b0; #1; Resetn = 1'b1;

        // 2: fixed priority
        b0.Req = 8'b0010_0100;
        tick();
        chk("fp_pend", 32'(b0.Pending), 32'h24);
        chk("fp_valid_lat", 32'(b0.Valid), 0);
        b0.Req = 8'h00;
        tick();
        chk("fp_valid1", 32'(b0.Valid), 1);
        chk("fp_code5", 32'(b0.Code), 5);
        b0.Ack = 1'b1;
        tick();
        chk("fp_gap", 32'(b0.Valid), 0);
        chk("fp_pend_after5", 32'(b0.Pending), 32'h04);
        b0.Ack = 1'b0;
        tick();
        chk("fp_valid2", 32'(b0.Valid), 1);
        chk("fp_code2", 32'(b0.Code), 2);
        b0.Ack = 1'b1;
        tick();
        b0.Ack = 1'b0;
        chk("fp_done_valid", 32'(b0.Valid), 0);
        chk("fp_done_pend", 32'(b0.Pending), 0);

        // 4: hold stability
        b0.Req = 8'h04;
        tick();
        b0.Req = 8'h00;
        tick();
        chk("hold_code_init", 32'(b0.Code), 2);
        b0.Req = 8'h80;
        for (int i = 0; i < 5; i++) begin
            tick();
            b0.Req = 8'h00;
            chk("hold_code", 32'(b0.Code), 2);
            chk("hold_valid", 32'(b0.Valid), 1);
        end
        b0.Ack = 1'b1;
        tick();
        b0.Ack = 1'b0;
        chk("hold_pend_after", 32'(b0.Pending), 32'h80);
        tick();
        chk("hold_next_code", 32'(b0.Code), 7);
        chk("hold_no_overrun", 32'(b0.Overrun), 0);
        b0.Ack = 1'b1;
        tick();
        b0.Ack = 1'b0;

        // 5: overrun
        b0.Req = 8'h08;
        tick();
        b0.Req = 8'h00;
        tick();
        chk("ovr_code3", 32'(b0.Code), 3);
        chk("ovr_before", 32'(b0.Overrun), 0);
        b0.Req = 8'h08;
        tick();
        b0.Req = 8'h00;
        chk("ovr_set", 32'(b0.Overrun), 1);
        b0.Ack = 1'b1;
        tick();
        b0.Ack = 1'b0;
        tick(); tick();
        chk("ovr_sticky", 32'(b0.Overrun), 1);
        chk("ovr_pend_clear", 32'(b0.Pending), 0);
        Resetn = 1'b0;
        #1;
        chk("ovr_reset", 32'(b0.Overrun), 0);
        Resetn = 1'b1;

        // 6: enable and reset mid-offer
        b0.Req = 8'h10;
        tick();
        b0.Req = 8'h00;
        tick();
        chk("en_code4", 32'(b0.Code), 4);
        b0.En = 1'b0; b0.Ack = 1'b1;
        tick();
        chk("en_off_valid", 32'(b0.Valid), 0);
        chk("en_off_code", 32'(b0.Code), 0);
        chk("en_off_pend", 32'(b0.Pending), 32'h10);
        b0.Ack = 1'b0;
        tick();
        chk("en_off_pend2", 32'(b0.Pending), 32'h10);
        b0.En = 1'b1;
        tick();
        chk("en_reoffer_valid", 32'(b0.Valid), 1);
        chk("en_reoffer_code", 32'(b0.Code), 4);
        #2;
        Resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(b0.Valid), 0);
        chk("mid_rst_code", 32'(b0.Code), 0);
        chk("mid_rst_pend", 32'(b0.Pending), 0);
        Resetn = 1'b1;
        b0.En = 1'b0;

        // 3: round-robin with held requests
        b1.En = 1'b1; b1.Req = 8'h81;
        tick();
        chk("rr_pend", 32'(b1.Pending), 32'h81);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_valid", 32'(b1.Valid), 1);
            chk("rr_code", 32'(b1.Code), (k % 2 == 0) ? 0 : 7);
            b1.Ack = 1'b1;
            tick();
            b1.Ack = 1'b0;
            chk("rr_gap", 32'(b1.Valid), 0);
            chk("rr_rearm", 32'(b1.Pending), 32'h81);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
